// File: rtl/uart_rx_if.sv
// Serial-in / parallel-out bundle between the UART receiver and its consumer.
// The receiver takes the slave modport. The master modport is for whoever drives the line and the baud tick.
interface uart_rx_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  i_16x_baud_en;
   logic                  i_rx;
   logic [DATA_WIDTH-1:0] o_rx_data;
   logic                  o_rx_valid;
   logic                  o_frame_err;
   logic                  o_parity_err;
   logic                  o_busy;

   modport master (
      output i_16x_baud_en, i_rx,
      input  o_rx_data, o_rx_valid, o_frame_err, o_parity_err, o_busy
   );

   modport slave (
      input  i_16x_baud_en, i_rx,
      output o_rx_data, o_rx_valid, o_frame_err, o_parity_err, o_busy
   );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, LSB-first, optional parity, one stop bit.
// Reports framing and parity errors with every completed word.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_IDLE      | line idle, waiting for a low sample on a tick
// S_START     | qualifying the start bit at its mid-point (tick 7)
// S_DATA      | sampling DATA_WIDTH data bits, one every 16 ticks
// S_PARITY    | sampling the parity bit
// S_STOP      | sampling the stop bit, publishing the word
// S_WAIT_HIGH | line held low after the frame (break / framing error)
module uart_rx #(
   parameter int DATA_WIDTH = 8,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0
) (
   input logic        clk,
   input logic        rst_n,
   uart_rx_if.slave   rx_bus
);

   localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_START     = 3'd1;
   localparam logic [2:0] S_DATA      = 3'd2;
   localparam logic [2:0] S_PARITY    = 3'd3;
   localparam logic [2:0] S_STOP      = 3'd4;
   localparam logic [2:0] S_WAIT_HIGH = 3'd5;

   logic                  rx_meta;
   logic                  rx_s;
   logic [2:0]            state;
   logic [3:0]            tick_cnt;
   logic [BW-1:0]         bit_cnt;
   logic [DATA_WIDTH-1:0] shift_reg;
   logic                  parity_bit;
   logic [DATA_WIDTH-1:0] rx_data;
   logic                  rx_valid;
   logic                  frame_err;
   logic                  parity_err;
   logic                  tick;
   logic                  parity_mis;

   assign tick       = rx_bus.i_16x_baud_en;
   assign parity_mis = (^shift_reg) ^ parity_bit ^ (PARITY_ODD != 0);

   // Synchroniser resets to the idle level so reset never fakes a start bit.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rx_bus.i_rx;
         rx_s    <= rx_meta;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         tick_cnt   <= 4'd0;
         bit_cnt    <= '0;
         shift_reg  <= '0;
         parity_bit <= 1'b0;
         rx_data    <= '0;
         rx_valid   <= 1'b0;
         frame_err  <= 1'b0;
         parity_err <= 1'b0;
      end else begin
         // Valid is cleared every clk so the pulse stays one cycle wide at any baud ratio.
         rx_valid <= 1'b0;
         if (tick) begin
            case (state)
               S_IDLE: begin
                  if (!rx_s) begin
                     tick_cnt <= 4'd0;
                     state    <= S_START;
                  end
               end
               S_START: begin
                  if (tick_cnt == 4'd7) begin
                     if (rx_s) begin
                        state <= S_IDLE;
                     end else begin
                        tick_cnt <= 4'd0;
                        bit_cnt  <= '0;
                        state    <= S_DATA;
                     end
                  end else begin
                     tick_cnt <= tick_cnt + 4'd1;
                  end
               end
               S_DATA: begin
                  tick_cnt <= tick_cnt + 4'd1;
                  if (tick_cnt == 4'd15) begin
                     shift_reg <= {rx_s, shift_reg[DATA_WIDTH-1:1]};
                     if (bit_cnt == BIT_LAST) begin
                        state <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
                     end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                     end
                  end
               end
               S_PARITY: begin
                  tick_cnt <= tick_cnt + 4'd1;
                  if (tick_cnt == 4'd15) begin
                     parity_bit <= rx_s;
                     state      <= S_STOP;
                  end
               end
               S_STOP: begin
                  tick_cnt <= tick_cnt + 4'd1;
                  if (tick_cnt == 4'd15) begin
                     rx_data    <= shift_reg;
                     frame_err  <= ~rx_s;
                     parity_err <= parity_mis && (PARITY_EN != 0);
                     rx_valid   <= 1'b1;
                     state      <= rx_s ? S_IDLE : S_WAIT_HIGH;
                  end
               end
               S_WAIT_HIGH: begin
                  if (rx_s) state <= S_IDLE;
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

   assign rx_bus.o_rx_data    = rx_data;
   assign rx_bus.o_rx_valid   = rx_valid;
   assign rx_bus.o_frame_err  = frame_err;
   assign rx_bus.o_parity_err = parity_err;
   assign rx_bus.o_busy       = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: an 8N1 instance and an 8O1 instance fed by a 21-clk baud tick.
// The expected results of each frame come from the bit pattern that was put on the line.
module tb_uart_rx;

   localparam int BIT_CLK = 336;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   int unsigned cyc = 0;
   int          checks = 0;
   int          failures = 0;

   logic [7:0]  q0_data[$];
   logic        q0_ferr[$];
   logic        q0_perr[$];
   int unsigned q0_t[$];
   logic [7:0]  q1_data[$];
   logic        q1_ferr[$];
   logic        q1_perr[$];

   uart_rx_if #(.DATA_WIDTH(8)) bus0 ();
   uart_rx_if #(.DATA_WIDTH(8)) bus1 ();

   uart_rx #(.DATA_WIDTH(8), .PARITY_EN(0), .PARITY_ODD(0)) dut0 (
      .clk    (clk),
      .rst_n  (rst_n),
      .rx_bus (bus0)
   );

   uart_rx #(.DATA_WIDTH(8), .PARITY_EN(1), .PARITY_ODD(1)) dut1 (
      .clk    (clk),
      .rst_n  (rst_n),
      .rx_bus (bus1)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Baud tick: one clk in every 21, shared by both receivers.
   initial begin
      int cnt;
      cnt = 0;
      bus0.i_16x_baud_en = 1'b0;
      bus1.i_16x_baud_en = 1'b0;
      forever begin
         @(negedge clk);
         bus0.i_16x_baud_en = (cnt == 20);
         bus1.i_16x_baud_en = (cnt == 20);
         cnt = (cnt == 20) ? 0 : cnt + 1;
      end
   end

   always @(negedge clk) begin
      if (bus0.o_rx_valid === 1'b1) begin
         q0_data.push_back(bus0.o_rx_data);
         q0_ferr.push_back(bus0.o_frame_err);
         q0_perr.push_back(bus0.o_parity_err);
         q0_t.push_back(cyc);
      end
      if (bus1.o_rx_valid === 1'b1) begin
         q1_data.push_back(bus1.o_rx_data);
         q1_ferr.push_back(bus1.o_frame_err);
         q1_perr.push_back(bus1.o_parity_err);
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_q();
      q0_data.delete(); q0_ferr.delete(); q0_perr.delete(); q0_t.delete();
      q1_data.delete(); q1_ferr.delete(); q1_perr.delete();
   endtask

   task automatic drive_bits(input int which, input logic [15:0] bits, input int n);
      for (int i = 0; i < n; i++) begin
         if (which == 0) bus0.i_rx = bits[i];
         else            bus1.i_rx = bits[i];
         repeat (BIT_CLK) @(negedge clk);
      end
   endtask

   function automatic logic [15:0] frame8(input logic [7:0] d, input logic stop);
      return {7'b0, stop, d, 1'b0};
   endfunction

   function automatic logic [15:0] frame_par(input logic [7:0] d, input logic p, input logic stop);
      return {5'b0, 1'b1, stop, p, d, 1'b0};
   endfunction

   // Odd parity: the data ones plus the parity bit must come to an odd count.
   function automatic logic model_perr_odd(input logic [7:0] d, input logic p);
      int ones;
      ones = int'(p);
      for (int i = 0; i < 8; i++) ones += int'(d[i]);
      return (ones % 2) == 0;
   endfunction

   task automatic expect_one(input int which, input string tag, input logic [7:0] d,
                             input logic ferr, input logic perr);
      int n;
      logic [7:0] od;
      logic of, op;
      n  = (which == 0) ? q0_data.size() : q1_data.size();
      check({tag, "_count"}, 32'(n), 32'd1);
      if (n > 0) begin
         od = (which == 0) ? q0_data[0] : q1_data[0];
         of = (which == 0) ? q0_ferr[0] : q1_ferr[0];
         op = (which == 0) ? q0_perr[0] : q1_perr[0];
         check({tag, "_data"}, 32'(od), 32'(d));
         check({tag, "_ferr"}, 32'(of), 32'(ferr));
         check({tag, "_perr"}, 32'(op), 32'(perr));
      end
   endtask

   initial begin
      logic [7:0] d;
      logic stop, p;
      int unsigned dt;

      bus0.i_rx = 1'b1;
      bus1.i_rx = 1'b1;
      rst_n = 1'b0;
      repeat (5) @(negedge clk);
      check("rst_data",  32'(bus0.o_rx_data),    32'h0);
      check("rst_valid", 32'(bus0.o_rx_valid),   32'h0);
      check("rst_ferr",  32'(bus0.o_frame_err),  32'h0);
      check("rst_perr",  32'(bus0.o_parity_err), 32'h0);
      check("rst_busy",  32'(bus0.o_busy),       32'h0);
      check("rst_busy1", 32'(bus1.o_busy),       32'h0);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);

      // Plain 8N1 frame
      clear_q();
      drive_bits(0, frame8(8'hA5, 1'b1), 10);
      drive_bits(0, 16'hFFFF, 1);
      expect_one(0, "t1", 8'hA5, 1'b0, 1'b0);
      check("t1_busy", 32'(bus0.o_busy), 32'h0);

      // Glitch shorter than half a bit is rejected
      clear_q();
      bus0.i_rx = 1'b0;
      repeat (30) @(negedge clk);
      check("t2_busy_hi", 32'(bus0.o_busy), 32'h1);
      repeat (33) @(negedge clk);
      bus0.i_rx = 1'b1;
      repeat (168) @(negedge clk);
      check("t2_busy_lo", 32'(bus0.o_busy), 32'h0);
      check("t2_count", 32'(q0_data.size()), 32'd0);
      check("t2_data", 32'(bus0.o_rx_data), 32'hA5);

      // Stop bit low, then break
      clear_q();
      drive_bits(0, frame8(8'h3C, 1'b0), 10);
      drive_bits(0, 16'h0000, 2);
      expect_one(0, "t3", 8'h3C, 1'b1, 1'b0);
      check("t3_busy_break", 32'(bus0.o_busy), 32'h1);
      drive_bits(0, 16'hFFFF, 1);
      check("t3_count_after", 32'(q0_data.size()), 32'd1);
      check("t3_busy_idle", 32'(bus0.o_busy), 32'h0);

      // Odd parity on the parity instance
      clear_q();
      drive_bits(1, frame_par(8'h01, 1'b0, 1'b1), 11);
      drive_bits(1, 16'hFFFF, 1);
      expect_one(1, "t4a", 8'h01, 1'b0, 1'b0);
      clear_q();
      drive_bits(1, frame_par(8'h01, 1'b1, 1'b1), 11);
      drive_bits(1, 16'hFFFF, 1);
      expect_one(1, "t4b", 8'h01, 1'b0, 1'b1);

      // Back-to-back frames, single stop bit
      clear_q();
      drive_bits(0, frame8(8'h00, 1'b1), 10);
      drive_bits(0, frame8(8'hFF, 1'b1), 10);
      drive_bits(0, 16'hFFFF, 1);
      check("t5_count", 32'(q0_data.size()), 32'd2);
      if (q0_data.size() >= 2) begin
         check("t5_data0", 32'(q0_data[0]), 32'h00);
         check("t5_data1", 32'(q0_data[1]), 32'hFF);
         dt = q0_t[1] - q0_t[0];
         check("t5_gap_ok", 32'(dt >= 3339 && dt <= 3381), 32'h1);
      end

      // Reset in the middle of data bit 3
      clear_q();
      drive_bits(0, 16'h0000, 4);
      bus0.i_rx = 1'b0;
      repeat (168) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("t6_data",  32'(bus0.o_rx_data),    32'h0);
      check("t6_valid", 32'(bus0.o_rx_valid),   32'h0);
      check("t6_ferr",  32'(bus0.o_frame_err),  32'h0);
      check("t6_perr",  32'(bus0.o_parity_err), 32'h0);
      check("t6_busy",  32'(bus0.o_busy),       32'h0);
      rst_n = 1'b1;
      drive_bits(0, 16'hFFFF, 2);
      check("t6_no_frame", 32'(q0_data.size()), 32'd0);
      clear_q();
      drive_bits(0, frame8(8'h5A, 1'b1), 10);
      drive_bits(0, 16'hFFFF, 1);
      expect_one(0, "t6_clean", 8'h5A, 1'b0, 1'b0);

      // Random frames on the 8N1 instance
      for (int k = 0; k < 4; k++) begin
         d    = 8'($urandom);
         stop = ($urandom_range(0, 3) != 0);
         clear_q();
         drive_bits(0, frame8(d, stop), 10);
         drive_bits(0, 16'hFFFF, 1);
         expect_one(0, "rnd_8n1", d, ~stop, 1'b0);
      end

      // Random frames on the 8O1 instance
      for (int k = 0; k < 4; k++) begin
         d    = 8'($urandom);
         p    = 1'($urandom);
         stop = ($urandom_range(0, 3) != 0);
         clear_q();
         drive_bits(1, frame_par(d, p, stop), 11);
         drive_bits(1, 16'hFFFF, 1);
         expect_one(1, "rnd_8o1", d, ~stop, model_perr_odd(d, p));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver that deserialises an asynchronous serial line into parallel words using the 16x oversampling enable from `uart_baud_rate`. The frame format is:

- 1 start bit.
- DATA_WIDTH data bits, LSB first.
- Optional parity bit.
- 1 stop bit.

The block sits between the pad-side RX pin and the parallel-side consumer (FIFO or register file). It reports framing and parity errors alongside each received word.

## Interface

Parameters:

- DATA_WIDTH, 8: data bits per frame. Legal range 5–9.
- PARITY_EN, 0: 1 means a parity bit follows the data bits.
- PARITY_ODD, 0: 1 selects odd parity, 0 selects even. Ignored when PARITY_EN=0.

Ports:

- clk  input  1  block clock; same clock as the `uart_baud_rate` instance.
- rst_n  input  1  reset, synchronous, active-low.
- i_16x_baud_en  input  1  single-cycle enable at 16x the baud rate.
- i_rx  input  1  asynchronous serial line; idles high.
- o_rx_data  output  DATA_WIDTH  last received word.
- o_rx_valid  output  1  one-cycle pulse when a frame completes.
- o_frame_err  output  1  stop bit of the last frame sampled low.
- o_parity_err  output  1  parity mismatch on the last frame.
- o_busy  output  1  high in every state except IDLE.

## Operation

- **Synchroniser.** i_rx passes through a 2-FF synchroniser, reset to 1. All decisions use the synchronised value `rx_s`.
- **Tick gating.** All state, tick-counter and bit-counter updates happen only on cycles where i_16x_baud_en=1. Output registers update on those same cycles.
- **Counters.**
  - 4-bit tick counter: counts 0..15 and wraps.
  - Bit counter: width ceil(log2(DATA_WIDTH)).
- **FSM states:** IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
- **IDLE**
  - On a tick with rx_s=0: clear the tick counter and go to START.
- **START**
  - On each tick, the tick counter increments.
  - At tick count 7 (mid-bit), if rx_s=1 it is a false start: go to IDLE with no output.
  - At tick count 7, if rx_s=0: clear the tick counter and the bit counter, then go to DATA.
- **DATA**
  - On each tick, the tick counter increments.
  - At tick count 15, rx_s is shifted into the MSB of the shift register (right shift), which yields LSB-first ordering.
  - After DATA_WIDTH samples, go to PARITY if PARITY_EN=1, otherwise go to STOP.
- **PARITY**
  - At tick count 15, sample rx_s as the parity bit.
  - A parity error exists when (XOR of data bits XOR parity bit XOR PARITY_ODD) is 1.
  - Go to STOP.
- **STOP**
  - At tick count 15, sample the stop bit.
  - On this tick, load o_rx_data from the shift register.
  - On this tick, set o_frame_err = ~rx_s and o_parity_err = (computed mismatch AND PARITY_EN).
  - On this tick, pulse o_rx_valid.
  - Next state: IDLE if rx_s=1, otherwise WAIT_HIGH.
- **WAIT_HIGH** (break or framing-error recovery)
  - Stay until a tick with rx_s=1, then go to IDLE.
  - No further frames are reported while the line is held low.
- **Output holding.** o_rx_data, o_frame_err and o_parity_err hold their values until the next frame completes. They are meaningful at every o_rx_valid pulse.
- **Frame completion.** A frame always completes with o_rx_valid, even when it has errors. There is no back-pressure; the consumer must accept the word on the pulse.
- **Reset.** rst_n=0 in any state, including mid-frame, forces the following on the next clk edge:
  - FSM to IDLE.
  - Counters to 0.
  - Synchroniser to 1.
  - o_rx_data=0, o_rx_valid=0, o_frame_err=0, o_parity_err=0, o_busy=0.

## Timing

- **Synchroniser latency.** 2 clk cycles from i_rx to rx_s.
- **Start detection resolution.** Start-edge detection has up to 1 tick of uncertainty.
- **Sample points.** Data, parity and stop bits are sampled 16 ticks apart, starting 16 ticks after the start-bit mid-point. This places each sample at the nominal bit centre.
- **o_rx_valid.**
  - Goes high in the clk cycle after the tick that samples the stop bit.
  - Is exactly 1 clk wide, regardless of baud ratio.
- **o_busy.**
  - Rises in the cycle after the tick that leaves IDLE.
  - Falls in the cycle after the tick that enters IDLE.
- **Back-to-back frames.** The FSM returns to IDLE at the middle of the stop bit, which leaves half a bit of slack. A following start bit immediately after a single stop bit must be received.

## Test plan

Common setup: baud generator parameters UART_CLK_FREQ_KHZ=40000 and UART_BAUD_RATE=115200. This gives a tick every 21 clk; 1 bit = 336 clk.

1. Send 0xA5 (8N1), stop bit high -> exactly one o_rx_valid pulse; o_rx_data=0xA5; o_frame_err=0; o_parity_err=0; o_busy=0 afterwards.
2. Drive i_rx low for 63 clk (3 ticks), then high -> no o_rx_valid; o_busy returns to 0 within 8 ticks; o_rx_data unchanged.
3. Send 0x3C with the stop bit low, then hold i_rx low for 2 bit times -> one o_rx_valid with o_rx_data=0x3C and o_frame_err=1. No second pulse until i_rx returns high and a new start bit arrives.
4. With PARITY_EN=1 and PARITY_ODD=1:
   - Send 0x01 with parity bit 0 -> o_parity_err=0.
   - Send 0x01 with parity bit 1 -> o_parity_err=1.
5. Send 0x00 then 0xFF back-to-back with one stop bit each -> two o_rx_valid pulses 3360 clk (±21) apart; data 0x00 then 0xFF.
6. Assert rst_n=0 for 1 clk during data bit 3 of a frame -> all outputs 0 on the next edge. A subsequent clean 0x5A frame is received correctly, with no error flags set.
